// File: rtl/dcache_writeback_pkg.sv
// Shared definitions for the dcache writeback buffer: system bus command
// codes, the writeback FSM state type and the buffered entry layout.
package dcache_writeback_pkg;

  localparam int ADDR_W     = 58;
  localparam int LINE_W     = 512;
  localparam int LINE_BEATS = 8;

  localparam logic [3:0] SYSBUS_READ   = 4'h0;
  localparam logic [3:0] SYSBUS_WRITE  = 4'h1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  // Request tag for a memory write: command at bit 8, target at bit 12.
  localparam logic [15:0] SYSBUS_WR_MEM_TAG =
    (16'(SYSBUS_WRITE) << 8) | (16'(SYSBUS_MEMORY) << 12);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } wb_entry_t;

endpackage

// File: rtl/dcache_writeback_fifo.sv
// Register FIFO of evicted lines. Every live entry is exposed oldest-first
// with an address-match bit so the owner can serve lookups from any of them,
// including the head while it is still being written out.
module wb_fifo
  import dcache_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             lookup_addr,
  output logic                          ready,
  output logic                          empty,
  output wb_entry_t                     head,
  output logic [DEPTH-1:0]              match_age,
  output logic [DEPTH-1:0][LINE_W-1:0]  line_age
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;

  // Occupancy after this edge; ready/empty are registered from it.
  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state: pointers, occupancy, per-entry valid bits and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      ready <= (count_nxt < CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Entry payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Present entries oldest-first so the newest match is the highest set bit.
  always_comb begin
    match_age = '0;
    line_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_age[i] = valid[rd_ptr + PTR_W'(i)] &&
                     (mem[rd_ptr + PTR_W'(i)].addr == lookup_addr);
      line_age[i]  = mem[rd_ptr + PTR_W'(i)].line;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dcache_writeback.sv
// Dirty-line writeback buffer on the dcache eviction path. Buffers evicted
// lines and writes each to memory as one address beat plus eight data beats,
// while answering lookups so a miss to a buffered line sees the fresh data.
module dcache_writeback
  import dcache_writeback_pkg::*;
#(
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [LINE_W-1:0]         wb_line,
  output logic                      wb_ready,
  output logic                      wb_empty,
  input  logic [ADDR_W-1:0]         lookup_addr,
  output logic                      lookup_hit,
  output logic [LINE_W-1:0]         lookup_line,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG = BUS_TAG_WIDTH'(SYSBUS_WR_MEM_TAG);
  localparam logic [2:0]               LAST_BEAT = 3'(LINE_BEATS - 1);

  wb_state_t                        state;
  logic [2:0]                       beat;
  logic                             push;
  logic                             pop;
  wb_entry_t                        push_entry;
  wb_entry_t                        head;
  logic [DEPTH-1:0]                 match_age;
  logic [DEPTH-1:0][LINE_W-1:0]     line_age;
  logic                             unused_ok;

  // Writes get no response, so the response channel is never consumed.
  assign unused_ok   = &{1'b0, bus_respcyc, bus_resp, bus_resptag, SYSBUS_READ};
  assign bus_respack = 1'b0;

  assign push       = wb_valid && wb_ready;
  assign pop        = (state == DATA) && bus_reqack && (beat == LAST_BEAT);
  assign push_entry = '{addr: wb_addr, line: wb_line};

  function automatic logic [BUS_DATA_WIDTH-1:0] line_word(
    input logic [LINE_W-1:0] l,
    input logic [2:0]        k
  );
    return l[int'(k) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  endfunction

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .lookup_addr (lookup_addr),
    .ready       (wb_ready),
    .empty       (wb_empty),
    .head        (head),
    .match_age   (match_age),
    .line_age    (line_age)
  );

  // Lookup: the newest matching entry wins, so later ages overwrite earlier ones.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_age[i]) begin
        lookup_hit  = 1'b1;
        lookup_line = line_age[i];
      end
    end
  end

  // Writeback FSM: address beat, eight held-until-acked data beats, one idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!wb_empty) begin
            state      <= ADDR;
            beat       <= '0;
            bus_reqcyc <= 1'b1;
            bus_req    <= BUS_DATA_WIDTH'({head.addr, 6'b0});
            bus_reqtag <= WR_TAG;
          end
        end
        ADDR: begin
          if (bus_reqack) begin
            state   <= DATA;
            beat    <= '0;
            bus_req <= line_word(head.line, 3'd0);
          end
        end
        DATA: begin
          if (bus_reqack) begin
            if (beat == LAST_BEAT) begin
              state      <= IDLE;
              bus_reqcyc <= 1'b0;
              bus_req    <= '0;
              bus_reqtag <= '0;
            end else begin
              beat    <= beat + 3'd1;
              bus_req <= line_word(head.line, beat + 3'd1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          bus_reqcyc <= 1'b0;
        end
      endcase
    end
  end

endmodule
